// File: rtl/bp_be_fe_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_fe_queue_buffer
// Purpose  : Checkpointing FIFO between the FE queue and the BE checker.
//            It supports speculative reads, commit (deq), roll and flush.
//            Define BP_BE_FE_QUEUE_BYPASS_EN for 0-cycle enqueue-to-output bypass.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_fe_queue_buffer #(
    parameter int els_p   = 8,
    parameter int width_p = 128
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,

    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,

    input  logic               deq_i,
    input  logic               roll_i,
    input  logic               clr_i,
    output logic               empty_o
);

    localparam int IDX_W = $clog2(els_p);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   cptr_q, cptr_d;
    logic [width_p-1:0] mem_q [els_p];

    logic w_full;
    logic w_enq;

    // Full when the write pointer is a whole lap ahead of the commit pointer.
    assign w_full           = (wptr_q[IDX_W] != cptr_q[IDX_W]) &&
                              (wptr_q[IDX_W-1:0] == cptr_q[IDX_W-1:0]);
    assign fe_queue_ready_o = ~w_full & ~reset_i;
    assign w_enq            = fe_queue_v_i & fe_queue_ready_o;
    assign empty_o          = (wptr_q == cptr_q);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end else begin
            wptr_d = wptr_q + PTR_W'(w_enq);
            cptr_d = cptr_q + PTR_W'(deq_i);
            // Roll lands on the commit pointer after any same-cycle commit.
            rptr_d = roll_i ? cptr_d : (rptr_q + PTR_W'(fe_queue_yumi_i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq && !clr_i) begin
            mem_q[wptr_q[IDX_W-1:0]] <= fe_queue_i;
        end
    end

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    logic w_bypass;

    // Entry is still written to storage so a later roll can replay it.
    assign w_bypass     = (rptr_q == wptr_q) & w_enq & ~clr_i & ~roll_i;
    assign fe_queue_o   = w_bypass ? fe_queue_i : mem_q[rptr_q[IDX_W-1:0]];
    assign fe_queue_v_o = (rptr_q != wptr_q) | w_bypass;
`else
    assign fe_queue_o   = mem_q[rptr_q[IDX_W-1:0]];
    assign fe_queue_v_o = (rptr_q != wptr_q);
`endif

endmodule
`default_nettype wire

// File: doc/bp_be_fe_queue_buffer.md
# bp_be_fe_queue_buffer

Checkpointing FIFO between the front end's `fe_queue` output and the back-end checker. It sits directly downstream of the FE top and buffers fetched-instruction and exception packets. The back end reads entries speculatively and frees them only on commit. On a misprediction or exception it can rewind the read pointer to the oldest uncommitted entry, or flush the whole buffer.

## Interface
- `els_p`, 8: entry count; power of two, ≥2.
- `width_p`, 128: packet width; set to `fe_queue_width_lp` at instantiation.
- `clk_i` input 1: clock.
- `reset_i` input 1: synchronous, active-high reset.
- `fe_queue_i` input `width_p`: packet from the FE.
- `fe_queue_v_i` input 1: FE packet valid.
- `fe_queue_ready_o` output 1: buffer can accept a packet.
- `fe_queue_o` output `width_p`: packet at the speculative read pointer.
- `fe_queue_v_o` output 1: `fe_queue_o` is valid.
- `fe_queue_yumi_i` input 1: BE consumes `fe_queue_o`.
  - Legal only while `fe_queue_v_o` is high.
  - Advances the read pointer.
- `deq_i` input 1: commit (free) the oldest entry.
- `roll_i` input 1: rewind the read pointer to the commit pointer.
- `clr_i` input 1: flush all entries.
- `empty_o` output 1: no entries are held, committed or otherwise.

## Operation
- The buffer has three pointers, each `$clog2(els_p)+1` bits wide, with the MSB acting as the wrap bit:
  - `wptr` is the write pointer.
  - `rptr` is the speculative read pointer.
  - `cptr` is the commit pointer.
- Invariant: `cptr ≤ rptr ≤ wptr` in modular order.
- Full: `wptr - cptr == els_p`, i.e. index bits equal and wrap bits differ.
- Empty: `wptr == cptr`.
- Output signals:
  - `fe_queue_ready_o = ~full & ~reset_i`.
  - `fe_queue_v_o = (rptr != wptr)`.
  - `empty_o = (wptr == cptr)`.
- Enqueue occurs when `fe_queue_v_i & fe_queue_ready_o`:
  - Storage at `wptr[idx]` is written.
  - `wptr` increments.
  - An enqueue attempted while full is ignored and no state changes.
- A yumi increments `rptr`.
- A deq increments `cptr`.
  - deq is legal only when `cptr != rptr`, i.e. the entry has already been read.
  - An illegal deq is a protocol error; the bench flags it.
- Event priority within one cycle:
  1. `clr_i`: `wptr`, `rptr` and `cptr` all go to 0. Any enqueue, yumi or deq in that cycle is discarded.
  2. `roll_i`: `rptr <= cptr_next`, where `cptr_next` includes a same-cycle deq. A same-cycle yumi is discarded. A same-cycle enqueue proceeds.
  3. Otherwise enqueue, yumi and deq are applied independently in the same cycle.
- Storage is flop or 1R1W array and is not reset. `fe_queue_o` is don't-care while `fe_queue_v_o` is low.
- Reset mid-operation behaves exactly like `clr_i`. All pointers are 0 on the cycle after `reset_i` falls.

## Timing
- Reset values:
  - `fe_queue_v_o` = 0.
  - `empty_o` = 1.
  - `fe_queue_ready_o` = 0 while `reset_i` is high, and 1 on the first cycle after reset.
- Enqueue-to-output latency is 1 cycle: a packet written in cycle N appears on `fe_queue_o` with `fe_queue_v_o` high in N+1 if `rptr` pointed to it.
- `fe_queue_o` and `fe_queue_v_o` are combinational from registered pointers and storage only. The exception is bypass mode (see Configuration).
- Full-to-ready recovery: a deq in cycle N raises `fe_queue_ready_o` in N+1.
- Roll visibility: a roll in cycle N presents the oldest uncommitted entry in N+1.
- Pointer wrap-around is handled by the wrap bit, with no special cycle cost.
- Throughput: one enqueue, one yumi and one deq per cycle, sustained.

## Configuration
- `BP_BE_FE_QUEUE_BYPASS_EN` defined:
  - When `rptr == wptr` and an enqueue occurs without `clr_i` or `roll_i`, the enqueue bypasses to the output.
  - In that case `fe_queue_o = fe_queue_i` and `fe_queue_v_o = 1` in the same cycle, giving 0-cycle latency.
  - A yumi in that cycle advances `rptr` together with `wptr`.
  - The entry is still written to storage so it can be rolled back.
- Undefined:
  - There is no combinational path from `fe_queue_i` or `fe_queue_v_i` to any output.
  - Latency is always 1 cycle.

## Test plan
- Fill and drain with `els_p=8`:
  - Enqueue 8 packets `0x1..0x8` with no yumi; after the 8th, `fe_queue_ready_o=0` and a 9th `0x9` is dropped.
  - Yumi and deq each packet in turn; packets emerge in order `0x1..0x8`, then `empty_o=1`.
- Roll:
  - Enqueue A, B, C; yumi A and B; deq A; assert `roll_i`.
  - Next cycle `fe_queue_o=B` with `fe_queue_v_o=1`; yumi B and C both succeed again.
- Simultaneous roll and deq:
  - With A, B, C read and none committed, assert `roll_i` and `deq_i` together.
  - Next cycle `fe_queue_o=B`.
- Clear with a concurrent enqueue:
  - Buffer holds 5 entries; assert `clr_i` while enqueueing `0xD`.
  - Next cycle `empty_o=1`, `fe_queue_v_o=0`, and `0xD` is lost.
- Wrap-around:
  - Perform 20 enqueue/yumi/deq iterations with a steady occupancy of 3.
  - Data stays in order, full is never falsely asserted, and every pointer wraps at least twice.
- Bypass, with the macro defined:
  - Enqueue `0x42` into an empty buffer and yumi it in the same cycle; `fe_queue_o=0x42` that cycle.
  - Then roll; `0x42` re-presents in the next cycle.
  - Without the macro, `0x42` is first visible one cycle after the enqueue.
